instr_encoder_loader: RTL and testbench

Encodes symbolic MIPS instruction requests into 32-bit machine words and streams them into instruction memory, so that program images can be loaded by a host or bench without a pre-assembled hex file. The block is the encoder counterpart of the pipelined CPU's opcode decoder. It produces exactly the opcode and funct set that the decoder recognises, buffers encoded words in a small FIFO, and writes them to consecutive word addresses through a stallable memory write port.

---
 rtl/instr_enc_pkg.sv | 44 ++++
 rtl/instr_enc_fifo.sv | 52 +++++
 rtl/instr_encoder_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared constants for the MIPS instruction encoder/loader: mnemonic codes,
// opcode/funct values and the loader FSM state type.
package instr_enc_pkg;

   localparam logic [3:0] MN_ADD  = 4'd0,
                          MN_SUB  = 4'd1,
                          MN_AND  = 4'd2,
                          MN_OR   = 4'd3,
                          MN_SLT  = 4'd4,
                          MN_LW   = 4'd5,
                          MN_SW   = 4'd6,
                          MN_BEQ  = 4'd7,
                          MN_BNE  = 4'd8,
                          MN_ADDI = 4'd9,
                          MN_ANDI = 4'd10,
                          MN_J    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000,
                          OP_LW    = 6'b100011,
                          OP_SW    = 6'b101011,
                          OP_BEQ   = 6'b000100,
                          OP_BNE   = 6'b000101,
                          OP_ADDI  = 6'b001000,
                          OP_ANDI  = 6'b001100,
                          OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000,
                          FN_SUB = 6'b100010,
                          FN_AND = 6'b100100,
                          FN_OR  = 6'b100101,
                          FN_SLT = 6'b101010;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   function automatic logic mnem_legal(input logic [3:0] m);
      return m <= MN_J;
   endfunction

   // Control-transfer words are the ones that get a trailing NOP slot.
   function automatic logic mnem_pads(input logic [3:0] m);
      return (m == MN_BEQ) || (m == MN_BNE) || (m == MN_J);
   endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Small synchronous FIFO holding encoded words; head is read straight from
// the registered storage so the write port sees a stable word.
module instr_enc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS requests and streams them into instruction memory.
// Define INSTR_ENC_NOP_PAD_EN to follow every BEQ/BNE/J with a zero word.
module instr_encoder_loader
   import instr_enc_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_mnem,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   input  logic        in_last,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [15:0] words_written,
   output logic        err_illegal,
   output logic        done
);
`ifdef INSTR_ENC_NOP_PAD_EN
   localparam int WIDTH = 33;
`else
   localparam int WIDTH = 32;
`endif
   localparam int CW = $clog2(DEPTH) + 1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] fifo_din;
   logic [WIDTH-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [31:0]      enc_word;
   logic             head_pad;
   logic             legal;
   logic             accept;
   logic             push;
   logic             commit;
   logic             pop;
   logic             pad_pending;
   logic             pad_after;
   logic             drain_empty;

   function automatic logic [31:0] encode(input logic [3:0]  m,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rd,
                                          input logic [15:0] imm,
                                          input logic [25:0] tgt);
      case (m)
         MN_ADD:  return {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
         MN_SUB:  return {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
         MN_AND:  return {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
         MN_OR:   return {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
         MN_SLT:  return {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
         MN_LW:   return {OP_LW,   rs, rt, imm};
         MN_SW:   return {OP_SW,   rs, rt, imm};
         MN_BEQ:  return {OP_BEQ,  rs, rt, imm};
         MN_BNE:  return {OP_BNE,  rs, rt, imm};
         MN_ADDI: return {OP_ADDI, rs, rt, imm};
         MN_ANDI: return {OP_ANDI, rs, rt, imm};
         MN_J:    return {OP_J, tgt};
         default: return 32'h0;
      endcase
   endfunction

   assign enc_word  = encode(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
   assign legal     = mnem_legal(in_mnem);
   assign accept    = in_valid && in_ready;
   assign push      = accept && legal;
   assign mem_we    = !fifo_empty || pad_pending;
   assign commit    = mem_we && mem_ready;
   assign pop       = commit && !pad_pending;
   assign mem_wdata = (!fifo_empty && !pad_pending) ? fifo_head[31:0] : 32'h0;

`ifdef INSTR_ENC_NOP_PAD_EN
   assign fifo_din = {mnem_pads(in_mnem), enc_word};
   assign head_pad = fifo_head[32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pad_pending <= 1'b0;
      else        pad_pending <= pad_after;
   end
`else
   assign fifo_din    = enc_word;
   assign head_pad    = 1'b0;
   assign pad_pending = 1'b0;
`endif

   // Look one edge ahead so done lands in the cycle right after the last commit.
   assign pad_after   = pad_pending ? !commit : (pop && head_pad);
   assign drain_empty = (fifo_empty || (pop && fifo_count == CW'(1))) && !pad_after;

   instr_enc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD: begin
            in_ready = !fifo_full;
            if (in_valid && !fifo_full && in_last) state_next = DRAIN;
         end
         DRAIN:   if (drain_empty) state_next = DONE;
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr      <= BASE_ADDR;
         words_written <= 16'h0;
         err_illegal   <= 1'b0;
      end else if (state == IDLE && start) begin
         mem_addr      <= BASE_ADDR;
         words_written <= 16'h0;
         err_illegal   <= 1'b0;
      end else begin
         if (commit) begin
            mem_addr <= mem_addr + 32'd4;
            if (words_written != 16'hFFFF) words_written <= words_written + 16'd1;
         end
         if (accept && !legal) err_illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a queue-based scoreboard of
// expected memory writes plus directed program loads with literal words.
module tb_instr_encoder_loader;

`ifdef INSTR_ENC_NOP_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_mnem;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] words_written;
   logic        err_illegal;
   logic        done;

   instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mnem       (in_mnem),
      .in_rs         (in_rs),
      .in_rt         (in_rt),
      .in_rd         (in_rd),
      .in_imm        (in_imm),
      .in_target     (in_target),
      .in_last       (in_last),
      .mem_we        (mem_we),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .words_written (words_written),
      .err_illegal   (err_illegal),
      .done          (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      bit          pad;
   } exp_t;

   int          n_checks = 0;
   int          n_errors = 0;
   bit          sim_over = 1'b0;
   int          done_seen = 0;
   exp_t        q[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   int          phase;
   logic [31:0] m_addr;
   logic [15:0] m_ww;
   bit          m_err;
   bit          m_ready;
   bit          m_we;
   bit          m_acc;
   int          occ;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Machine words straight from the MIPS opcode/funct tables.
   function automatic logic [31:0] model_enc(input logic [3:0] m, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [15:0] imm, input logic [25:0] tgt);
      case (m)
         4'd0:    return {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
         4'd1:    return {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
         4'd2:    return {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
         4'd3:    return {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
         4'd4:    return {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
         4'd5:    return {6'b100011, rs, rt, imm};
         4'd6:    return {6'b101011, rs, rt, imm};
         4'd7:    return {6'b000100, rs, rt, imm};
         4'd8:    return {6'b000101, rs, rt, imm};
         4'd9:    return {6'b001000, rs, rt, imm};
         4'd10:   return {6'b001100, rs, rt, imm};
         4'd11:   return {6'b000010, tgt};
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic last);
      bit ok;
      in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = done;
      end
      tick();
      check("done_pulse", 32'(got), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_mnem = 4'd0;
      in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0;
      in_target = 26'h0; in_last = 1'b0; mem_ready = 1'b0;
      phase = 0; m_addr = BASE; m_ww = 16'h0; m_err = 1'b0;
      fork
         // Scoreboard: compare against the model, then advance it for the coming edge.
         begin
            while (!sim_over) begin
               @(negedge clk);
               if (!rst_n) begin
                  q.delete(); phase = 0; m_addr = BASE; m_ww = 16'h0; m_err = 1'b0;
               end
               occ = 0;
               foreach (q[i]) if (!q[i].pad) occ++;
               m_ready = (phase == 1) && (occ < DEPTH);
               m_we    = (q.size() > 0);
               check("in_ready", 32'(in_ready), 32'(m_ready));
               check("mem_we", 32'(mem_we), 32'(m_we));
               check("mem_addr", mem_addr, m_addr);
               if (m_we) check("mem_wdata", mem_wdata, q[0].data);
               check("words_written", 32'(words_written), 32'(m_ww));
               check("err_illegal", 32'(err_illegal), 32'(m_err));
               check("done", 32'(done), 32'(phase == 3));
               if (done) done_seen++;
               if (rst_n) begin
                  if (m_we && mem_ready) begin
                     log_addr.push_back(mem_addr);
                     log_data.push_back(mem_wdata);
                     void'(q.pop_front());
                     m_addr += 32'd4;
                     if (m_ww != 16'hFFFF) m_ww++;
                  end
                  m_acc = in_valid && m_ready;
                  if (m_acc) begin
                     if (in_mnem <= 4'd11) begin
                        q.push_back('{model_enc(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target), 1'b0});
                        if (PAD && (in_mnem == 4'd7 || in_mnem == 4'd8 || in_mnem == 4'd11))
                           q.push_back('{32'h0, 1'b1});
                     end else begin
                        m_err = 1'b1;
                     end
                  end
                  case (phase)
                     0: if (start) begin
                        phase = 1; m_addr = BASE; m_ww = 16'h0; m_err = 1'b0;
                     end
                     1: if (m_acc && in_last) phase = 2;
                     2: if (q.size() == 0) phase = 3;
                     default: phase = 0;
                  endcase
               end
            end
         end
         begin
            int base;
            logic [31:0] hold_addr;
            logic [31:0] hold_data;
            logic [31:0] exp3 [4];
            int n3;

            $display("[TB] reset and idle");
            tick(); tick();
            @(negedge clk);
            check("rst_mem_addr", mem_addr, BASE);
            check("rst_mem_wdata", mem_wdata, 32'h0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            tick();
            rst_n = 1'b1;
            in_valid = 1'b1; in_mnem = 4'd0;
            repeat (3) begin
               @(negedge clk);
               check("idle_in_ready", 32'(in_ready), 32'd0);
               tick();
            end
            in_valid = 1'b0;

            $display("[TB] program load");
            mem_ready = 1'b1;
            base = log_data.size();
            pulse_start();
            send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
            pulse_start();
            send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1);
            wait_done();
            check("load_count", 32'(log_data.size() - base), 32'd2);
            check("load_w0", log_data[base], 32'h0022_1820);
            check("load_a0", log_addr[base], 32'h0);
            check("load_w1", log_data[base+1], 32'h8C08_0004);
            check("load_a1", log_addr[base+1], 32'h4);
            check("load_ww", 32'(words_written), 32'd2);

            $display("[TB] branch/jump words");
            base = log_data.size();
            if (PAD) begin
               exp3 = '{32'h1022_FFFF, 32'h0, 32'h0800_0010, 32'h0};
               n3 = 4;
            end else begin
               exp3 = '{32'h1022_FFFF, 32'h0800_0010, 32'h0, 32'h0};
               n3 = 2;
            end
            pulse_start();
            send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0);
            send(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
            wait_done();
            check("pad_count", 32'(log_data.size() - base), 32'(n3));
            for (int i = 0; i < n3 && base + i < log_data.size(); i++) begin
               check("pad_word", log_data[base+i], exp3[i]);
               check("pad_addr", log_addr[base+i], 32'(4*i));
            end
            check("pad_ww", 32'(words_written), 32'(n3));

            $display("[TB] illegal mnemonic");
            base = log_data.size();
            pulse_start();
            send(4'd13, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h0, 1'b0);
            send(4'd9, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b1);
            wait_done();
            check("ill_err", 32'(err_illegal), 32'd1);
            check("ill_count", 32'(log_data.size() - base), 32'd1);
            check("ill_word", log_data[base], 32'h2001_0005);
            check("ill_addr", log_addr[base], BASE);
            check("ill_ww", 32'(words_written), 32'd1);
            pulse_start();
            @(negedge clk);
            check("err_cleared", 32'(err_illegal), 32'd0);
            tick();
            send(4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1);
            wait_done();

            $display("[TB] backpressure");
            mem_ready = 1'b0;
            base = log_data.size();
            pulse_start();
            for (int i = 0; i < 4; i++)
               send(4'd1, 5'(i+1), 5'(i+2), 5'(i+3), 16'h0, 26'h0, 1'b0);
            in_mnem = 4'd0; in_rs = 5'd5; in_rt = 5'd6; in_rd = 5'd7; in_last = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_head", mem_wdata, 32'h0022_1822);
            check("bp_addr", mem_addr, 32'h0);
            hold_addr = mem_addr;
            hold_data = mem_wdata;
            tick();
            @(negedge clk);
            check("bp_stable_addr", mem_addr, hold_addr);
            check("bp_stable_data", mem_wdata, hold_data);
            tick();
            mem_ready = 1'b1;
            send(4'd0, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b1);
            wait_done();
            check("bp_count", 32'(log_data.size() - base), 32'd5);
            check("bp_w1", log_data[base+1], 32'h0043_2022);
            check("bp_w4", log_data[base+4], 32'h00A6_3820);
            check("bp_a4", log_addr[base+4], 32'h10);
            check("bp_ww", 32'(words_written), 32'd5);

            $display("[TB] reset during drain");
            mem_ready = 1'b0;
            pulse_start();
            for (int i = 0; i < 3; i++)
               send(4'd3, 5'(i), 5'(i), 5'(i), 16'h0, 26'h0, 1'(i == 2));
            tick();
            rst_n = 1'b0;
            @(negedge clk);
            check("mrst_mem_we", 32'(mem_we), 32'd0);
            check("mrst_ww", 32'(words_written), 32'd0);
            check("mrst_addr", mem_addr, BASE);
            hold_addr = 32'(done_seen);
            tick();
            rst_n = 1'b1;
            mem_ready = 1'b1;
            in_valid = 1'b1;
            repeat (10) tick();
            in_valid = 1'b0;
            check("mrst_no_done", 32'(done_seen), hold_addr);
            check("mrst_idle_ready", 32'(in_ready), 32'd0);

            sim_over = 1'b1;
            tick();
            tick();
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
